// File: rtl/mux_stream_nch.sv
// N-channel registered stream multiplexer with fixed-select or round-robin grant.
// The output is a single registered entry tagged with the channel the word came from.
module mux_stream_nch #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    logic                vld_p0;
    logic [WIDTH-1:0]    data_p0;
    logic [SEL_W-1:0]    ch_p0;
    logic [SEL_W-1:0]    last_grant;

    logic                can_accept;
    logic                grant_any;
    logic                xfer;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic [SEL_W-1:0]    cand;

    assign can_accept = !vld_p0 || out_ready;

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!mode) begin
            // An out-of-range sel never matches any channel, so nothing is granted.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan farthest-first so the nearest valid channel after last_grant wins.
            for (int k = CHANNELS; k >= 1; k--) begin
                cand = SEL_W'((int'(last_grant) + k) % CHANNELS);
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cand == SEL_W'(i) && in_valid[i]) begin
                        grant     = '0;
                        grant[i]  = 1'b1;
                        grant_any = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign in_ready = (can_accept && !reset) ? grant : '0;
    assign xfer     = grant_any && can_accept;

    // Stage p0: output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            data_p0    <= '0;
            ch_p0      <= '0;
            last_grant <= SEL_W'(CHANNELS - 1);
        end else begin
            if (xfer) begin
                vld_p0  <= 1'b1;
                data_p0 <= grant_data;
                ch_p0   <= grant_idx;
                if (mode) last_grant <= grant_idx;
            end else if (out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_ch    = ch_p0;

endmodule

// File: tb/tb_mux_stream_nch.sv
// Scoreboard bench for mux_stream_nch: directed vectors, expected words queued at issue
// and popped by a monitor whenever the output handshake completes.
module tb_mux_stream_nch;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] in_valid;
    logic [7:0] in_data;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [1:0] out_ch;
    logic       out_ready;

    logic       mode3;
    logic [1:0] sel3;
    logic [2:0] in_valid3;
    logic [5:0] in_data3;
    logic [2:0] in_ready3;
    logic       out_valid3;
    logic [1:0] out_data3;
    logic [1:0] out_ch3;
    logic       out_ready3;

    int n_cmp = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    localparam logic [7:0] PA = 8'b11_10_01_00;
    localparam logic [7:0] PB = 8'b00_01_10_11;

    always #5 clk = ~clk;

    mux_stream_nch #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_stream_nch #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            logic [3:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {out_data, out_ch}, 4'hx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[3:2]));
                chk("sb_ch", 32'(out_ch), 32'(e[1:0]));
            end
        end
    end

    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic [7:0] d, input logic rdy, input logic do_chk,
                        input logic [3:0] exp_rdy, input logic push,
                        input logic [1:0] exp_data, input logic [1:0] exp_ch);
        mode = m; sel = s; in_valid = v; in_data = d; out_ready = rdy;
        if (push) exp_q.push_back({exp_data, exp_ch});
        @(negedge clk);
        if (do_chk) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] ch;
        logic [3:0] oh;
        logic [1:0] sparse [4];
        sparse[0] = 2'd1; sparse[1] = 2'd3; sparse[2] = 2'd1; sparse[3] = 2'd3;

        reset = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = '0; in_data3 = 6'b01_11_10; out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        in_valid = 4'hf;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fixed select, channel 2
        step(0, 2'd2, 4'hf, PA, 1, 1, 4'b0100, 1, 2'b10, 2'd2);
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        step(0, 2'd2, 4'h0, PA, 1, 0, 4'b0, 0, 2'b0, 2'd0);
        chk("t1_drained", 32'(out_valid), 32'h0);
        chk("t1_data_hold", 32'(out_data), 32'h2);

        // Round-robin, all valid then sparse
        for (int k = 0; k < 8; k++) begin
            ch = 2'(k % 4);
            oh = 4'b0001 << ch;
            step(1, 2'd0, 4'hf, PB, 1, 1, oh, 1, 2'd3 - ch, ch);
            chk("t2_stream_valid", 32'(out_valid), 32'h1);
        end
        for (int k = 0; k < 4; k++) begin
            ch = sparse[k];
            oh = 4'b0001 << ch;
            step(1, 2'd0, 4'b1010, PB, 1, 1, oh, 1, 2'd3 - ch, ch);
        end
        step(1, 2'd0, 4'h0, PB, 1, 1, 4'b0, 0, 2'b0, 2'd0);
        chk("t2_drained", 32'(out_valid), 32'h0);

        // Backpressure then same-cycle reload
        step(0, 2'd1, 4'b0010, PA, 0, 1, 4'b0010, 1, 2'b01, 2'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, 2'd2, 4'b0100, PA, 0, 1, 4'b0000, 0, 2'b0, 2'd0);
            chk("t3_hold_valid", 32'(out_valid), 32'h1);
            chk("t3_hold_data", 32'(out_data), 32'h1);
            chk("t3_hold_ch", 32'(out_ch), 32'h1);
        end
        step(0, 2'd2, 4'b0100, PA, 1, 1, 4'b0100, 1, 2'b10, 2'd2);
        chk("t3_reload_valid", 32'(out_valid), 32'h1);
        chk("t3_reload_ch", 32'(out_ch), 32'h2);
        step(0, 2'd0, 4'h0, PA, 1, 0, 4'b0, 0, 2'b0, 2'd0);
        chk("t3_drained", 32'(out_valid), 32'h0);

        // Out-of-range select on the 3-channel instance
        in_valid3 = 3'b111; sel3 = 2'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_in_ready", 32'(in_ready3), 32'h0);
            chk("t4_out_valid", 32'(out_valid3), 32'h0);
        end
        @(posedge clk); #1;
        sel3 = 2'd2;
        @(negedge clk);
        chk("t4_sel2_ready", 32'(in_ready3), 32'h4);
        @(posedge clk); #1;
        in_valid3 = 3'b000;
        chk("t4_sel2_valid", 32'(out_valid3), 32'h1);
        chk("t4_sel2_ch", 32'(out_ch3), 32'h2);
        chk("t4_sel2_data", 32'(out_data3), 32'h1);

        // Reset mid-operation discards the held word and restores the pointer
        step(1, 2'd0, 4'b0100, PB, 0, 1, 4'b0100, 0, 2'b0, 2'd0);
        chk("t5_held_valid", 32'(out_valid), 32'h1);
        chk("t5_held_ch", 32'(out_ch), 32'h2);
        reset = 1'b1;
        step(1, 2'd0, 4'hf, PB, 0, 1, 4'b0000, 0, 2'b0, 2'd0);
        reset = 1'b0;
        chk("t5_rst_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_data", 32'(out_data), 32'h0);
        chk("t5_rst_ch", 32'(out_ch), 32'h0);
        step(1, 2'd0, 4'hf, PB, 1, 1, 4'b0001, 1, 2'd3, 2'd0);

        // Fixed-mode transfers leave the round-robin pointer alone
        step(1, 2'd0, 4'hf, PB, 1, 1, 4'b0010, 1, 2'd2, 2'd1);
        step(0, 2'd0, 4'hf, PB, 1, 1, 4'b0001, 1, 2'd3, 2'd0);
        step(0, 2'd0, 4'hf, PB, 1, 1, 4'b0001, 1, 2'd3, 2'd0);
        step(1, 2'd0, 4'hf, PB, 1, 1, 4'b0100, 1, 2'd1, 2'd2);
        step(1, 2'd0, 4'h0, PB, 1, 0, 4'b0, 0, 2'b0, 2'd0);
        step(1, 2'd0, 4'h0, PB, 1, 0, 4'b0, 0, 2'b0, 2'd0);
        chk("t6_drained", 32'(out_valid), 32'h0);
        chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_stream_nch.md
Name: mux_stream_nch

Overview:
- Parametrised successor to the team's 2-bit two-input select mux.
- N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two grant modes: externally selected channel (fixed) or round-robin arbitration.
- Sits between the datapath producers and a shared downstream consumer; the output is registered, one entry deep, and tags each word with its source channel.

Parameters:
WIDTH, 2, data width per channel in bits (>=1)
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, width of channel index; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via sel; 1 = round-robin
sel  input  SEL_W  channel index used when mode=0
in_valid  input  CHANNELS  per-channel valid; bit i = channel i
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  CHANNELS  per-channel ready (combinational)
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered data word
out_ch  output  SEL_W  source channel of out_data
out_ready  input  1  downstream accepts the word this cycle

Behaviour:
- Clocking: single clock `clk`. Reset `reset` is synchronous and active-high; it is sampled only on the rising edge.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_grant = CHANNELS-1, so channel 0 has first priority after reset.
  - in_ready is forced to all-zero while reset is high.
- can_accept = !out_valid || out_ready (combinational).
- Grant (combinational, one-hot or zero):
  - mode=0: grant channel sel if sel < CHANNELS and in_valid[sel]=1. If sel >= CHANNELS, no grant; in_ready=0 on all channels.
  - mode=1: scan channels last_grant+1, last_grant+2, … modulo CHANNELS and grant the first with in_valid=1. If none is valid, no grant.
- in_ready[i] = can_accept && (i is the granted channel). All other bits are 0. in_ready never asserts on a channel with in_valid=0.
- Input transfer: in_valid[i] && in_ready[i] at a rising edge. On transfer, the next cycle has out_valid=1, out_data=in_data[i], out_ch=i. Latency is 1 cycle.
- Output drain: out_valid && out_ready with no new transfer in the same cycle -> out_valid=0. out_data and out_ch hold their last values.
- Simultaneous drain and accept: the register reloads in the same cycle. Throughput is 1 word/cycle with no bubble.
- Backpressure: out_valid=1 && out_ready=0 -> out_data and out_ch hold stable; in_ready is all-zero.
- Pointer update: last_grant updates to the granted index only on an input transfer, and only when mode=1. In mode=0 the pointer holds.
- Mode or sel change while out_valid=1: the held word is unaffected. The new mode/sel applies from the next grant decision.
- Reset mid-operation: any held word is discarded (out_valid=0 next cycle); the pointer returns to CHANNELS-1.
- No combinational path from in_data to out_data; all outputs except in_ready are registered.

Test Plan:
1. Fixed mode: mode=0, sel=2, in_valid=4'b1111, ch2 data=2'b10, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=2'b10, out_ch=2.
2. Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1, 8 cycles after reset -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle. Sparse case: in_valid=4'b1010 -> sequence 1,3,1,3.
3. Backpressure: out_valid=1, out_ch=1, out_data=2'b01, out_ready=0 for 3 cycles -> out_data and out_ch stable, in_ready=0. Then raise out_ready with ch2 valid -> same-cycle reload, out_ch=2.
4. Out-of-range select: CHANNELS=3, SEL_W=2, mode=0, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid stays 0.
5. Reset mid-operation: out_valid=1, pointer at 2; assert reset for 1 cycle -> out_valid=0, out_data=0, out_ch=0. With in_valid=4'b1111 in mode 1, the first grant goes to channel 0.
6. Mode switch: mode 1 with last grant=1; switch to mode=0, sel=0 for 2 words; return to mode 1 -> the next RR grant is channel 2 (pointer unchanged by fixed-mode transfers).
